// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared definitions for the OV7670 video path: capture FSM states, buffer
// address / pixel widths and the default frame geometry, which the VGA reader
// uses as well so both sides agree on the buffer layout.
package ov7670_pkg;

  localparam int FRAME_ADDR_W = 19;
  localparam int PIXEL_W      = 4;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/ov7670_byte_pair.sv
// ov7670_byte_pair
// Pairs consecutive camera bytes into pixels and selects the luminance byte.
// Ports:
//   pclk, rst    - camera pixel clock, async active-high reset
//   enable       - pairing allowed (capture FSM in ACTIVE, frame not ending)
//   href         - registered line-valid
//   data         - registered camera byte
//   pixel_valid  - high in the cycle the second byte of a pair is present
//   luma         - luminance[7:4] of the completed pixel, valid with pixel_valid
module ov7670_byte_pair
  import ov7670_pkg::*;
#(
  parameter int Y_BYTE = 0
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               enable,
  input  logic               href,
  input  logic [7:0]         data,
  output logic               pixel_valid,
  output logic [PIXEL_W-1:0] luma
);

  logic byte_ph;
  logic unused_chroma;

  // byte_ph restarts at 0 whenever href drops or pairing is disabled, so an
  // odd trailing byte or a half pixel cut by VSYNC is silently discarded.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      byte_ph <= 1'b0;
    end else if (enable && href) begin
      byte_ph <= ~byte_ph;
    end else begin
      byte_ph <= 1'b0;
    end
  end

  assign pixel_valid   = enable & href & byte_ph;
  assign unused_chroma = ^data[3:0];

  generate
    if (Y_BYTE == 0) begin : g_y_first
      logic [PIXEL_W-1:0] y_hold;

      // Luminance arrives first, so hold it until the pair completes.
      always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
          y_hold <= '0;
        end else if (enable && href && !byte_ph) begin
          y_hold <= data[7:4];
        end
      end

      assign luma = y_hold;
    end else begin : g_y_second
      assign luma = data[7:4];
    end
  endgenerate

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture
// Camera-side receiver: samples the OV7670 bus on pclk, frames it with VSYNC,
// pairs bytes into pixels and writes 4-bit luminance into the frame buffer.
// Ports:
//   pclk, rst          - camera pixel clock, async active-high reset
//   cam_vsync/href/data- raw camera bus
//   capture_en         - capture gate, sampled at frame start only
//   err_clr            - synchronous clear of the sticky error flags
//   frame_addr/pixel/we- buffer write port (one strobe per pixel)
//   frame_done         - one-cycle pulse when a captured frame ends
//   frame_count        - captured frame counter, wraps
//   err_line_short/long, err_frame_long - sticky geometry errors
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int   H_PIXELS     = DEF_H_PIXELS,
  parameter int   V_LINES      = DEF_V_LINES,
  parameter int   ADDR_BASE    = 0,
  parameter int   Y_BYTE       = 0,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    cam_vsync,
  input  logic                    cam_href,
  input  logic [7:0]              cam_data,
  input  logic                    capture_en,
  input  logic                    err_clr,
  output logic [FRAME_ADDR_W-1:0] frame_addr,
  output logic [PIXEL_W-1:0]      frame_pixel,
  output logic                    frame_we,
  output logic                    frame_done,
  output logic [7:0]              frame_count,
  output logic                    err_line_short,
  output logic                    err_line_long,
  output logic                    err_frame_long
);

  localparam int COL_W = $clog2(H_PIXELS + 1) + 1;
  localparam int ROW_W = $clog2(V_LINES + 2) + 1;

  localparam logic [COL_W-1:0]        COL_MAX = COL_W'(H_PIXELS);
  localparam logic [COL_W-1:0]        COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0]        ROW_MAX = ROW_W'(V_LINES);
  localparam logic [ROW_W-1:0]        ROW_SAT = ROW_W'(V_LINES + 1);
  localparam logic [ROW_W-1:0]        ROW_ONE = ROW_W'(1);
  localparam logic [FRAME_ADDR_W-1:0] BASE    = FRAME_ADDR_W'(ADDR_BASE);
  localparam logic [FRAME_ADDR_W-1:0] ADR_ONE = FRAME_ADDR_W'(1);

  cap_state_t state, state_nx;

  logic                    vs_r, vs_r_prev, hr_r, hr_r_prev;
  logic [7:0]              d_r;
  logic                    vs_on, vs_rise, vs_fall;
  logic                    frame_start, frame_end;
  logic                    pair_en, pixel_valid;
  logic [PIXEL_W-1:0]      luma;
  logic                    line_start, line_end;
  logic                    col_full, row_ok, do_write;
  logic                    set_short, set_long, set_flong;
  logic                    cap_act;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [FRAME_ADDR_W-1:0] wr_addr;

  // Single register stage on the camera bus. The VSYNC copies reset to the
  // active level so a pulse already in progress at reset release is never
  // mistaken for a fresh active edge: capture needs a complete pulse.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_r      <= VSYNC_ACTIVE;
      vs_r_prev <= VSYNC_ACTIVE;
      hr_r      <= 1'b0;
      hr_r_prev <= 1'b0;
      d_r       <= 8'd0;
    end else begin
      vs_r      <= cam_vsync;
      vs_r_prev <= vs_r;
      hr_r      <= cam_href;
      hr_r_prev <= hr_r;
      d_r       <= cam_data;
    end
  end

  assign vs_on   = (vs_r == VSYNC_ACTIVE);
  assign vs_rise = vs_on && (vs_r_prev != VSYNC_ACTIVE);
  assign vs_fall = !vs_on && (vs_r_prev == VSYNC_ACTIVE);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= SYNC_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // Frame framing: a frame runs from the VSYNC inactive edge to the next
  // active edge; SYNC_WAIT throws away whatever frame was in flight at reset.
  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (vs_rise) state_nx = VBLANK;
      end
      VBLANK: begin
        if (vs_fall) begin
          state_nx    = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_nx  = VBLANK;
          frame_end = 1'b1;
        end
      end
      default: state_nx = SYNC_WAIT;
    endcase
  end

  // The frame-ending edge disables pairing so a half pixel there is dropped.
  assign pair_en = (state == ACTIVE) && !vs_rise;

  ov7670_byte_pair #(
    .Y_BYTE (Y_BYTE)
  ) u_byte_pair (
    .pclk        (pclk),
    .rst         (rst),
    .enable      (pair_en),
    .href        (hr_r),
    .data        (d_r),
    .pixel_valid (pixel_valid),
    .luma        (luma)
  );

  assign line_start = pair_en && hr_r && !hr_r_prev;
  assign line_end   = pair_en && !hr_r && hr_r_prev;
  assign col_full   = (col >= COL_MAX);
  assign row_ok     = (row < ROW_MAX);
  assign do_write   = pixel_valid && cap_act && !col_full && row_ok;
  assign set_short  = line_end && !col_full;
  assign set_long   = pixel_valid && col_full;
  assign set_flong  = line_start && !row_ok;

  // Geometry counters and the buffer write port. Counters run even when
  // capture is gated off so geometry errors are still reported. The address
  // only advances on real writes, which bounds it to the buffer size.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cap_act     <= 1'b0;
      col         <= '0;
      row         <= '0;
      wr_addr     <= BASE;
      frame_addr  <= BASE;
      frame_pixel <= '0;
      frame_we    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_we   <= do_write;
      frame_done <= frame_end && cap_act;
      if (frame_end && cap_act) begin
        frame_count <= frame_count + 8'd1;
      end
      if (frame_start) begin
        cap_act    <= capture_en;
        col        <= '0;
        row        <= '0;
        wr_addr    <= BASE;
        frame_addr <= BASE;
      end else begin
        if (do_write) begin
          frame_addr  <= wr_addr;
          frame_pixel <= luma;
          wr_addr     <= wr_addr + ADR_ONE;
        end
        if (line_end) begin
          col <= '0;
          if (row != ROW_SAT) row <= row + ROW_ONE;
        end else if (pixel_valid && !col_full) begin
          col <= col + COL_ONE;
        end
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      err_line_short <= 1'b0;
      err_line_long  <= 1'b0;
      err_frame_long <= 1'b0;
    end else begin
      err_line_short <= (err_line_short & ~err_clr) | set_short;
      err_line_long  <= (err_line_long  & ~err_clr) | set_long;
      err_frame_long <= (err_frame_long & ~err_clr) | set_flong;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture
// Directed bench for ov7670_capture with a 4x2 frame geometry. Per-frame
// scenarios live in a table; write address/pixel expectations come from a
// small line-length model. Hand-written sequences cover write latency and
// reset in the middle of a line.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        capture_en;
  logic        err_clr;
  logic [18:0] frame_addr;
  logic [3:0]  frame_pixel;
  logic        frame_we;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        err_line_short;
  logic        err_line_long;
  logic        err_frame_long;

  ov7670_capture #(
    .H_PIXELS     (H),
    .V_LINES      (V),
    .ADDR_BASE    (0),
    .Y_BYTE       (0),
    .VSYNC_ACTIVE (1'b1)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_data       (cam_data),
    .capture_en     (capture_en),
    .err_clr        (err_clr),
    .frame_addr     (frame_addr),
    .frame_pixel    (frame_pixel),
    .frame_we       (frame_we),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .err_line_short (err_line_short),
    .err_line_long  (err_line_long),
    .err_frame_long (err_frame_long)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit cap_en;
    int nlines;
    int len0;
    int len1;
    int len2;
    int exp_writes;
    int exp_done;
    int exp_count;
    bit exp_short;
    bit exp_long;
    bit exp_flong;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // Write/done log sampled on the falling edge, away from the active edge.
  logic [18:0] wr_addr_log[$];
  logic [3:0]  wr_pix_log[$];
  int          done_count = 0;

  always @(negedge pclk) begin
    if (frame_we === 1'b1) begin
      wr_addr_log.push_back(frame_addr);
      wr_pix_log.push_back(frame_pixel);
    end
    if (frame_done === 1'b1) done_count++;
  end

  logic [18:0] exp_addr_q[$];
  logic [3:0]  exp_pix_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one pclk worth of href/data, changing just after the rising edge.
  task automatic applyStimulus(input logic hr, input logic [7:0] d);
    @(posedge pclk);
    #1;
    cam_href = hr;
    cam_data = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00);
  endtask

  // Pixel p of a line: Y alternates A0/50, chroma alternates 3C/C3.
  function automatic logic [7:0] byte_of(input int k);
    if (k % 2 == 0) return ((k / 2) % 2 == 0) ? 8'hA0 : 8'h50;
    return ((k / 2) % 2 == 0) ? 8'h3C : 8'hC3;
  endfunction

  task automatic send_bytes(input int from, input int to);
    for (int k = from; k < to; k++) applyStimulus(1'b1, byte_of(k));
  endtask

  task automatic send_line(input int nbytes);
    send_bytes(0, nbytes);
    idle(4);
  endtask

  task automatic vsync_rise();
    @(posedge pclk);
    #1;
    cam_vsync = 1'b1;
    idle(5);
  endtask

  task automatic vsync_fall();
    @(posedge pclk);
    #1;
    cam_vsync = 1'b0;
    idle(4);
  endtask

  function automatic int line_len(input vec_t v, input int l);
    case (l)
      0:       return v.len0;
      1:       return v.len1;
      default: return v.len2;
    endcase
  endfunction

  // Expected writes: only the first V lines and first H pixels of each line,
  // addresses packed back to back from 0.
  task automatic build_expect(input vec_t v);
    int a;
    int npix;
    exp_addr_q.delete();
    exp_pix_q.delete();
    a = 0;
    if (v.cap_en) begin
      for (int l = 0; l < v.nlines && l < V; l++) begin
        npix = line_len(v, l) / 2;
        for (int p = 0; p < npix && p < H; p++) begin
          exp_addr_q.push_back(19'(a));
          exp_pix_q.push_back((p % 2 == 0) ? 4'hA : 4'h5);
          a++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wbase;
    int dbase;
    int n;

    vecs[0] = '{cap_en:1'b1, nlines:2, len0:8,  len1:8, len2:0, exp_writes:8,
                exp_done:1, exp_count:1, exp_short:1'b0, exp_long:1'b0, exp_flong:1'b0};
    vecs[1] = '{cap_en:1'b1, nlines:2, len0:6,  len1:8, len2:0, exp_writes:7,
                exp_done:1, exp_count:2, exp_short:1'b1, exp_long:1'b0, exp_flong:1'b0};
    vecs[2] = '{cap_en:1'b1, nlines:2, len0:10, len1:8, len2:0, exp_writes:8,
                exp_done:1, exp_count:3, exp_short:1'b0, exp_long:1'b1, exp_flong:1'b0};
    vecs[3] = '{cap_en:1'b0, nlines:2, len0:8,  len1:8, len2:0, exp_writes:0,
                exp_done:0, exp_count:3, exp_short:1'b0, exp_long:1'b0, exp_flong:1'b0};
    vecs[4] = '{cap_en:1'b1, nlines:3, len0:8,  len1:8, len2:8, exp_writes:8,
                exp_done:1, exp_count:4, exp_short:1'b0, exp_long:1'b0, exp_flong:1'b1};
    vecs[5] = '{cap_en:1'b1, nlines:2, len0:8,  len1:8, len2:0, exp_writes:8,
                exp_done:1, exp_count:5, exp_short:1'b0, exp_long:1'b0, exp_flong:1'b0};

    // Reset with VSYNC already high: the pulse in progress must not count.
    rst        = 1'b1;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    capture_en = 1'b1;
    err_clr    = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checkOutput("reset frame_addr", 32'(frame_addr), 32'd0);
    checkOutput("reset frame_pixel", 32'(frame_pixel), 32'd0);
    checkOutput("reset frame_we", 32'(frame_we), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset frame_count", 32'(frame_count), 32'd0);
    checkOutput("reset err_line_short", 32'(err_line_short), 32'd0);
    checkOutput("reset err_line_long", 32'(err_line_long), 32'd0);
    checkOutput("reset err_frame_long", 32'(err_frame_long), 32'd0);
    @(posedge pclk);
    #1;
    rst = 1'b0;
    idle(3);

    // Frame started mid-pulse: ignored entirely.
    wbase = wr_addr_log.size();
    dbase = done_count;
    vsync_fall();
    send_line(8);
    send_line(8);
    vsync_rise();
    checkOutput("ignored frame writes", 32'(wr_addr_log.size() - wbase), 32'd0);
    checkOutput("ignored frame done", 32'(done_count - dbase), 32'd0);

    for (int i = 0; i < 6; i++) begin
      wbase = wr_addr_log.size();
      dbase = done_count;
      capture_en = vecs[i].cap_en;
      vsync_fall();
      for (int l = 0; l < vecs[i].nlines; l++) begin
        send_line(line_len(vecs[i], l));
        capture_en = 1'b1;
      end
      vsync_rise();

      build_expect(vecs[i]);
      n = wr_addr_log.size() - wbase;
      checkOutput($sformatf("v%0d write count", i), 32'(n), 32'(vecs[i].exp_writes));
      checkOutput($sformatf("v%0d model count", i), 32'(n), 32'(exp_addr_q.size()));
      for (int k = 0; k < n && k < exp_addr_q.size(); k++) begin
        checkOutput($sformatf("v%0d addr[%0d]", i, k), 32'(wr_addr_log[wbase + k]),
                    32'(exp_addr_q[k]));
        checkOutput($sformatf("v%0d pixel[%0d]", i, k), 32'(wr_pix_log[wbase + k]),
                    32'(exp_pix_q[k]));
      end
      checkOutput($sformatf("v%0d frame_done", i), 32'(done_count - dbase),
                  32'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d frame_count", i), 32'(frame_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("v%0d err_line_short", i), 32'(err_line_short),
                  32'(vecs[i].exp_short));
      checkOutput($sformatf("v%0d err_line_long", i), 32'(err_line_long),
                  32'(vecs[i].exp_long));
      checkOutput($sformatf("v%0d err_frame_long", i), 32'(err_frame_long),
                  32'(vecs[i].exp_flong));

      @(posedge pclk);
      #1;
      err_clr = 1'b1;
      @(posedge pclk);
      #1;
      err_clr = 1'b0;
      @(negedge pclk);
      checkOutput($sformatf("v%0d cleared flags", i),
                  32'({err_line_short, err_line_long, err_frame_long}), 32'd0);
    end

    // Write latency: strobe appears two edges after the second byte is on
    // the pins (sampled on the first, written on the second).
    wbase = wr_addr_log.size();
    capture_en = 1'b1;
    vsync_fall();
    applyStimulus(1'b1, 8'hA0);
    applyStimulus(1'b1, 8'h3C);
    @(posedge pclk);
    #1;
    cam_href = 1'b0;
    cam_data = 8'h00;
    @(negedge pclk);
    checkOutput("latency we early", 32'(frame_we), 32'd0);
    @(negedge pclk);
    checkOutput("latency we on time", 32'(frame_we), 32'd1);
    checkOutput("latency addr", 32'(frame_addr), 32'd0);
    checkOutput("latency pixel", 32'(frame_pixel), 32'hA);
    @(negedge pclk);
    checkOutput("latency we single", 32'(frame_we), 32'd0);
    idle(4);

    // Reset in the middle of a line after three writes of that line.
    wbase = wr_addr_log.size();
    send_bytes(0, 8);
    @(posedge pclk);
    #2;
    checkOutput("pre-reset writes", 32'(wr_addr_log.size() - wbase), 32'd3);
    checkOutput("pre-reset last addr", 32'(wr_addr_log[wr_addr_log.size() - 1]), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("async reset frame_we", 32'(frame_we), 32'd0);
    checkOutput("async reset frame_addr", 32'(frame_addr), 32'd0);
    checkOutput("async reset frame_pixel", 32'(frame_pixel), 32'd0);
    checkOutput("async reset frame_count", 32'(frame_count), 32'd0);
    checkOutput("async reset err_line_short", 32'(err_line_short), 32'd0);
    send_bytes(0, 2);
    @(posedge pclk);
    #1;
    rst = 1'b0;
    wbase = wr_addr_log.size();
    send_bytes(2, 8);
    idle(4);
    send_line(8);
    checkOutput("no write before vsync", 32'(wr_addr_log.size() - wbase), 32'd0);
    vsync_rise();
    vsync_fall();
    send_line(8);
    n = wr_addr_log.size() - wbase;
    checkOutput("restart write count", 32'(n), 32'd4);
    if (n > 0) begin
      checkOutput("restart first addr", 32'(wr_addr_log[wbase]), 32'd0);
      checkOutput("restart first pixel", 32'(wr_pix_log[wbase]), 32'hA);
    end
    if (n > 3) begin
      checkOutput("restart last addr", 32'(wr_addr_log[wbase + 3]), 32'd3);
      checkOutput("restart last pixel", 32'(wr_pix_log[wbase + 3]), 32'h5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
